multicycle_ctrl: RTL

Multi-cycle control FSM that sequences the single-issue RV32I-subset datapath: owns the program counter (instAddr into the instruction ROM), latches instructions, and issues the register-file write strobe (regWrite), data-memory handshakes and operand/writeback selects. Sits between the instruction ROM, ALU, data memory and register file inside driver; one instruction is in flight at a time.

---
 rtl/multicycle_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the single-issue RV32I-subset datapath.
// Owns the PC and retired count, latches the instruction, and sequences strobes and selects.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for run=1
// S_FETCH  | ir_write=1, inst latched into IR on exit
// S_DECODE | classify opcode; illegal/ECALL goes to S_HALT
// S_EXEC   | ALU step; branches commit here
// S_MEM    | load/store handshake held until mem_ready
// S_WB     | register writeback; R/I/LOAD/JAL commit here
// S_HALT   | sticky fault, left only through reset
module multicycle_ctrl #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [31:0]       inst,
  input  logic              branch_taken,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] instAddr,
  output logic              ir_write,
  output logic              alu_src_imm,
  output logic              mem_read,
  output logic              mem_write,
  output logic              regWrite,
  output logic [1:0]        wb_sel,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t            state, state_nxt;
  logic [31:0]       ir;
  logic [ADDR_W-1:0] pc_nxt, pc_inc, target;
  logic              commit;

  logic [6:0] opcode;
  logic       is_r, is_i, is_ld, is_st, is_br, is_jal, legal;

  assign opcode = ir[6:0];
  assign is_r   = (opcode == 7'b0110011);
  assign is_i   = (opcode == 7'b0010011);
  assign is_ld  = (opcode == 7'b0000011);
  assign is_st  = (opcode == 7'b0100011);
  assign is_br  = (opcode == 7'b1100011);
  assign is_jal = (opcode == 7'b1101111);
  assign legal  = is_r | is_i | is_ld | is_st | is_br | is_jal;

  // Byte offsets become word offsets by arithmetic shift (floor toward -inf).
  logic signed [31:0] imm_b, imm_j, imm_sel, offs;
  assign imm_b   = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j   = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign imm_sel = is_jal ? imm_j : imm_b;
  assign offs    = imm_sel >>> 2;
  assign target  = instAddr + offs[ADDR_W-1:0];
  assign pc_inc  = instAddr + ADDR_W'(1);

  logic unused_ok;
  assign unused_ok = ^{offs[31:ADDR_W]};

  always_comb begin
    state_nxt = state;
    pc_nxt    = instAddr;
    commit    = 1'b0;
    case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_ld || is_st) begin
          state_nxt = S_MEM;
        end else if (is_br) begin
          commit = 1'b1;
          pc_nxt = branch_taken ? target : pc_inc;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_ld) begin
            state_nxt = S_WB;
          end else begin
            commit = 1'b1;
            pc_nxt = pc_inc;
          end
        end
      end
      S_WB: begin
        commit = 1'b1;
        pc_nxt = is_jal ? target : pc_inc;
      end
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
    // run is only honoured at instruction boundaries.
    if (commit) state_nxt = run ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      instAddr <= '0;
      retired  <= '0;
      ir       <= '0;
    end else begin
      state    <= state_nxt;
      instAddr <= pc_nxt;
      if (commit) retired <= retired + CNT_W'(1);
      if (state == S_FETCH) ir <= inst;
    end
  end

  // Outputs depend only on state and the latched IR, never directly on inputs.
  always_comb begin
    ir_write    = 1'b0;
    alu_src_imm = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    regWrite    = 1'b0;
    wb_sel      = 2'd0;
    busy        = 1'b1;
    halted      = 1'b0;
    case (state)
      S_IDLE:  busy = 1'b0;
      S_FETCH: ir_write = 1'b1;
      S_EXEC:  alu_src_imm = is_i | is_ld | is_st;
      S_MEM: begin
        mem_read  = is_ld;
        mem_write = is_st;
      end
      S_WB: begin
        regWrite = (ir[11:7] != 5'd0);
        wb_sel   = is_ld ? 2'd1 : (is_jal ? 2'd2 : 2'd0);
      end
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
